uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_tx_arbiter_rr_arbiter.sv | 27 ++
 rtl/uart_tx_arbiter.sv | 159 +++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and limits for the UART TX arbiter slice.
package uart_pkg;

    localparam int REQ_MIN    = 2;
    localparam int REQ_MAX    = 8;
    localparam int LOCK_CNT_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACTIVE  = 2'd1,
        ST_RELEASE = 2'd2
    } arb_state_e;

    function automatic bit requesters_ok(input int n);
        return (n >= REQ_MIN) && (n <= REQ_MAX);
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_arbiter.sv
// Round-robin priority search: first requester above the last winner,
// wrapping to the lowest index when nothing above it is requesting.
module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N-1:0]     grant_o,
    output logic             valid_o
);

    // Upper pass covers indices above the pointer, lower pass handles the wrap.
    always_comb begin
        grant_o = '0;
        valid_o = 1'b0;
        for (int k = 0; k < N; k++) begin
            grant_o[k] = req_i[k] && (IDX_W'(k) > ptr_i) && !valid_o;
            valid_o    = valid_o | grant_o[k];
        end
        for (int k = 0; k < N; k++) begin
            grant_o[k] = grant_o[k] | (req_i[k] && !valid_o);
            valid_o    = valid_o | grant_o[k];
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART TX register port among REQUESTERS bus masters with
// round-robin arbitration, packet locking and a lock idle timeout.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int REQUESTERS   = 4,
    parameter int LOCK_TIMEOUT = 1024
) (
    input  logic                       i_clock,
    input  logic                       i_reset,
    input  logic [REQUESTERS-1:0]      i_request,
    input  logic [2*REQUESTERS-1:0]    i_address,
    input  logic [32*REQUESTERS-1:0]   i_wdata,
    input  logic [REQUESTERS-1:0]      i_lock,
    output logic [REQUESTERS-1:0]      o_ready,
    output logic                       o_request,
    output logic [1:0]                 o_address,
    output logic [31:0]                o_wdata,
    input  logic                       i_ready,
    output logic [REQUESTERS-1:0]      o_grant,
    output logic                       o_busy
);

    localparam int IDX_W = $clog2(REQUESTERS);

    if (!requesters_ok(REQUESTERS)) begin : g_bad_requesters
        $error("uart_tx_arbiter: REQUESTERS outside supported range");
    end

    arb_state_e              state_q;
    logic [REQUESTERS-1:0]   grant_q;
    logic [IDX_W-1:0]        last_q;
    logic [REQUESTERS-1:0]   lock_q;
    logic [REQUESTERS-1:0]   lock_d;
    logic [LOCK_CNT_W-1:0]   lock_cnt_q;
    logic [LOCK_CNT_W-1:0]   lock_cnt_d;

    logic [REQUESTERS-1:0]   eligible_s;
    logic [REQUESTERS-1:0]   arb_grant_s;
    logic                    arb_valid_s;
    logic                    owner_req_s;
    logic                    owner_lock_s;
    logic [IDX_W-1:0]        owner_idx_s;
    logic [1:0]              owner_addr_s;
    logic [31:0]             owner_wdata_s;
    logic                    lock_held_s;
    logic                    lock_pin_s;
    logic                    lock_req_s;
    logic                    active_s;
    logic                    xfer_end_s;

    assign lock_held_s = |lock_q;
    assign lock_pin_s  = |(i_lock & lock_q);
    assign lock_req_s  = |(i_request & lock_q);
    assign eligible_s  = lock_held_s ? (i_request & lock_q) : i_request;

    rr_arbiter #(
        .N     (REQUESTERS),
        .IDX_W (IDX_W)
    ) u_rr_arbiter (
        .req_i   (eligible_s),
        .ptr_i   (last_q),
        .grant_o (arb_grant_s),
        .valid_o (arb_valid_s)
    );

    // AND-OR mux of the owner's slices, selected by the registered one-hot grant.
    always_comb begin
        owner_req_s   = 1'b0;
        owner_lock_s  = 1'b0;
        owner_idx_s   = '0;
        owner_addr_s  = 2'b00;
        owner_wdata_s = 32'h0000_0000;
        for (int k = 0; k < REQUESTERS; k++) begin
            owner_req_s   = owner_req_s  | (grant_q[k] & i_request[k]);
            owner_lock_s  = owner_lock_s | (grant_q[k] & i_lock[k]);
            owner_idx_s   = owner_idx_s  | (grant_q[k] ? IDX_W'(k) : '0);
            owner_addr_s  = owner_addr_s | ({2{grant_q[k]}} & i_address[2*k +: 2]);
            owner_wdata_s = owner_wdata_s | ({32{grant_q[k]}} & i_wdata[32*k +: 32]);
        end
    end

    // A transfer ends on completion or when the owner withdraws its request.
    assign active_s   = (state_q == ST_ACTIVE) && !i_reset;
    assign xfer_end_s = (state_q == ST_ACTIVE) && (i_ready || !owner_req_s);

    assign o_request = active_s & owner_req_s;
    assign o_address = active_s ? owner_addr_s : 2'b00;
    assign o_wdata   = active_s ? owner_wdata_s : 32'h0000_0000;
    assign o_ready   = active_s ? (grant_q & {REQUESTERS{i_ready}}) : '0;
    assign o_grant   = i_reset ? '0 : grant_q;
    assign o_busy    = !i_reset && (state_q != ST_IDLE);

    // Lock ownership and the idle-with-lock timeout counter.
    always_comb begin
        lock_d     = lock_q;
        lock_cnt_d = lock_cnt_q;
        if (xfer_end_s && owner_lock_s) begin
            lock_d     = grant_q;
            lock_cnt_d = '0;
        end else if (lock_held_s && !lock_pin_s) begin
            lock_d     = '0;
            lock_cnt_d = '0;
        end else if ((state_q == ST_IDLE) && arb_valid_s) begin
            lock_cnt_d = '0;
        end else if ((state_q == ST_IDLE) && lock_held_s && !lock_req_s) begin
            if (lock_cnt_q == LOCK_CNT_W'(LOCK_TIMEOUT - 1)) begin
                lock_d     = '0;
                lock_cnt_d = '0;
            end else begin
                lock_cnt_d = lock_cnt_q + 16'd1;
            end
        end else begin
            lock_cnt_d = lock_cnt_q;
        end
    end

    // Arbitration FSM, grant register and last-winner pointer.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q    <= ST_IDLE;
            grant_q    <= '0;
            last_q     <= IDX_W'(REQUESTERS - 1);
            lock_q     <= '0;
            lock_cnt_q <= '0;
        end else begin
            lock_q     <= lock_d;
            lock_cnt_q <= lock_cnt_d;
            case (state_q)
                ST_IDLE: begin
                    if (arb_valid_s) begin
                        state_q <= ST_ACTIVE;
                        grant_q <= arb_grant_s;
                    end else begin
                        state_q <= ST_IDLE;
                        grant_q <= '0;
                    end
                end
                ST_ACTIVE: begin
                    if (xfer_end_s) begin
                        state_q <= ST_RELEASE;
                        last_q  <= owner_idx_s;
                    end else begin
                        state_q <= ST_ACTIVE;
                    end
                end
                ST_RELEASE: begin
                    state_q <= ST_IDLE;
                    grant_q <= '0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    grant_q <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: requester agents and a UART responder
// driven per cycle, completions checked against an expected-order scoreboard.
module tb_uart_tx_arbiter;

    localparam int NREQ    = 4;
    localparam int LOCK_TO = 8;

    logic          i_clock;
    logic          i_reset;
    logic [3:0]    i_request;
    logic [7:0]    i_address;
    logic [127:0]  i_wdata;
    logic [3:0]    i_lock;
    logic [3:0]    o_ready;
    logic          o_request;
    logic [1:0]    o_address;
    logic [31:0]   o_wdata;
    logic          i_ready;
    logic [3:0]    o_grant;
    logic          o_busy;

    uart_tx_arbiter #(
        .REQUESTERS   (NREQ),
        .LOCK_TIMEOUT (LOCK_TO)
    ) dut (
        .i_clock   (i_clock),
        .i_reset   (i_reset),
        .i_request (i_request),
        .i_address (i_address),
        .i_wdata   (i_wdata),
        .i_lock    (i_lock),
        .o_ready   (o_ready),
        .o_request (o_request),
        .o_address (o_address),
        .o_wdata   (o_wdata),
        .i_ready   (i_ready),
        .o_grant   (o_grant),
        .o_busy    (o_busy)
    );

    typedef struct {
        int          id;
        logic [1:0]  addr;
        logic [31:0] data;
    } exp_t;

    exp_t       exp_q[$];
    int         checks = 0;
    int         errors = 0;
    int         jobs[4];
    int         job_no[4];
    int         exp_job[4];
    bit         abort_arm[4];
    bit         aborted;
    logic [3:0] rdy_last;
    logic [3:0] lock_want;
    int         resp_cnt;
    int         resp_lat;

    initial begin
        i_clock = 1'b0;
        forever #5 i_clock = ~i_clock;
    end

    function automatic logic [1:0] addr_of(input int g, input int j);
        return 2'((g + j) % 4);
    endfunction

    function automatic logic [31:0] data_of(input int g, input int j);
        return 32'h0000_0041 + 32'(g) * 32'h0000_0100 + 32'(j) * 32'h0001_0000;
    endfunction

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, req);
        end
    endfunction

    task automatic expect_xfer(input int g);
        exp_t e;
        e.id   = g;
        e.addr = addr_of(g, exp_job[g]);
        e.data = data_of(g, exp_job[g]);
        exp_q.push_back(e);
        exp_job[g]++;
    endtask

    // One clock: sample completions, then update responder and requester agents.
    task automatic step();
        @(negedge i_clock);
        rdy_last = o_ready;
        @(posedge i_clock);
        #1;
        aborted = 1'b0;
        if (o_request) begin
            resp_cnt++;
            i_ready = (resp_cnt == resp_lat);
        end else begin
            resp_cnt = 0;
            i_ready  = 1'b0;
        end
        for (int g = 0; g < NREQ; g++) begin
            if (abort_arm[g] && o_grant[g] && o_request) begin
                abort_arm[g] = 1'b0;
                aborted      = 1'b1;
                jobs[g]--;
                job_no[g]++;
            end else if (rdy_last[g]) begin
                jobs[g]--;
                job_no[g]++;
            end
            i_request[g]          = (jobs[g] > 0);
            i_address[2*g +: 2]   = addr_of(g, job_no[g]);
            i_wdata[32*g +: 32]   = data_of(g, job_no[g]);
        end
        i_lock = lock_want;
        #1;
    endtask

    task automatic wait_done(input string name, input int max);
        int n;
        n = 0;
        while (((jobs[0] + jobs[1] + jobs[2] + jobs[3]) != 0 || o_busy) && n < max) begin
            step();
            n++;
        end
        check({name, " finished in budget"}, 64'(n < max), 64'd1);
    endtask

    // Scoreboard monitor: every completion pulse must match the expected order.
    initial begin
        exp_t       e;
        logic [3:0] want;
        forever begin
            @(negedge i_clock);
            if (o_ready != 4'b0000) begin
                check("ready onehot", 64'($countones(o_ready)), 64'd1);
                if (exp_q.size() == 0) begin
                    check("unexpected completion", 64'(o_ready), 64'd0);
                end else begin
                    e    = exp_q.pop_front();
                    want = 4'b0001 << e.id;
                    check("ready owner", 64'(o_ready), 64'(want));
                    check("grant owner", 64'(o_grant), 64'(want));
                    check("request high", 64'(o_request), 64'd1);
                    check("address", 64'(o_address), 64'(e.addr));
                    check("wdata", 64'(o_wdata), 64'(e.data));
                end
            end
        end
    end

    initial begin
        int n;
        int idle_n;
        i_reset   = 1'b1;
        i_request = 4'b0000;
        i_address = 8'h00;
        i_wdata   = 128'h0;
        i_lock    = 4'b0000;
        i_ready   = 1'b0;
        lock_want = 4'b0000;
        rdy_last  = 4'b0000;
        resp_cnt  = 0;
        resp_lat  = 3;
        aborted   = 1'b0;
        for (int g = 0; g < NREQ; g++) begin
            jobs[g] = 0; job_no[g] = 0; exp_job[g] = 0; abort_arm[g] = 1'b0;
        end

        repeat (3) step();
        check("reset grant", 64'(o_grant), 64'd0);
        check("reset busy", 64'(o_busy), 64'd0);
        check("reset request", 64'(o_request), 64'd0);
        check("reset ready", 64'(o_ready), 64'd0);
        i_reset = 1'b0;
        step();
        check("post reset busy", 64'(o_busy), 64'd0);
        check("post reset wdata", 64'(o_wdata), 64'd0);

        // Single transfer from requester 0, one RELEASE cycle afterwards.
        expect_xfer(0);
        jobs[0] = 1;
        n = 0;
        while (!rdy_last[0] && n < 20) begin step(); n++; end
        check("t1 completion seen", 64'(n < 20), 64'd1);
        check("t1 release busy", 64'(o_busy), 64'd1);
        check("t1 release grant", 64'(o_grant), 64'h1);
        check("t1 release request", 64'(o_request), 64'd0);
        step();
        check("t1 idle busy", 64'(o_busy), 64'd0);
        check("t1 idle grant", 64'(o_grant), 64'd0);

        // All four held from reset: order 0,1,2,3,0.
        i_reset = 1'b1;
        jobs[0] = 2; jobs[1] = 1; jobs[2] = 1; jobs[3] = 1;
        step();
        step();
        check("t2 reset grant", 64'(o_grant), 64'd0);
        i_reset = 1'b0;
        expect_xfer(0); expect_xfer(1); expect_xfer(2); expect_xfer(3); expect_xfer(0);
        wait_done("t2", 200);

        // Locked burst from requester 1 holds off requester 2.
        lock_want = 4'b0010;
        jobs[1] = 3; jobs[2] = 1;
        expect_xfer(1); expect_xfer(1); expect_xfer(1);
        n = 0;
        while (jobs[1] != 0 && n < 200) begin step(); n++; end
        check("t3 burst done", 64'(n < 200), 64'd1);
        repeat (3) step();
        check("t3 locked grant", 64'(o_grant), 64'd0);
        check("t3 locked busy", 64'(o_busy), 64'd0);
        lock_want = 4'b0000;
        expect_xfer(2);
        wait_done("t3", 100);

        // Lock held by an idle requester 1 expires after LOCK_TO idle cycles.
        lock_want = 4'b0010;
        jobs[1] = 1;
        expect_xfer(1);
        n = 0;
        while (!rdy_last[1] && n < 40) begin step(); n++; end
        check("t4 lock xfer seen", 64'(n < 40), 64'd1);
        jobs[3] = 1;
        expect_xfer(3);
        idle_n = 0;
        step();
        while (!o_busy && idle_n < 40) begin idle_n++; step(); end
        check("t4 idle cycles", 64'(idle_n), 64'(LOCK_TO + 1));
        check("t4 grant", 64'(o_grant), 64'h8);
        wait_done("t4", 100);
        lock_want = 4'b0000;

        // Requester 2 aborts; pointer still advances so 3 beats 0.
        abort_arm[2] = 1'b1;
        jobs[2] = 1; jobs[3] = 1;
        exp_job[2]++;
        n = 0;
        while (!aborted && n < 40) begin step(); n++; end
        check("t5 abort seen", 64'(n < 40), 64'd1);
        check("t5 abort request", 64'(o_request), 64'd0);
        check("t5 abort ready", 64'(o_ready), 64'd0);
        check("t5 abort grant", 64'(o_grant), 64'h4);
        jobs[0] = 1;
        expect_xfer(3); expect_xfer(0);
        step();
        check("t5 release busy", 64'(o_busy), 64'd1);
        check("t5 release request", 64'(o_request), 64'd0);
        wait_done("t5", 100);

        // Reset in ACTIVE drops everything; requester 0 is served first after.
        resp_lat = 30;
        jobs[2] = 1;
        n = 0;
        while (!(o_busy && o_grant == 4'b0100) && n < 40) begin step(); n++; end
        check("t6 active seen", 64'(n < 40), 64'd1);
        i_reset = 1'b1;
        jobs[0] = 1;
        #1;
        check("t6 in reset request", 64'(o_request), 64'd0);
        check("t6 in reset ready", 64'(o_ready), 64'd0);
        step();
        check("t6 after reset request", 64'(o_request), 64'd0);
        check("t6 after reset grant", 64'(o_grant), 64'd0);
        check("t6 after reset busy", 64'(o_busy), 64'd0);
        resp_lat = 3;
        step();
        i_reset = 1'b0;
        expect_xfer(0); expect_xfer(2);
        wait_done("t6", 200);

        repeat (3) step();
        check("scoreboard drained", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
